// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single strobe/ack memory bus.
// Define MEM_ARBITER_TIMEOUT_EN to force-complete WAIT after TIMEOUT_CYCLES.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       pend_q, pend_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0][31:0] addr_q, addr_d;
  logic [1:0][31:0] wdata_q, wdata_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic [1:0]       ack_q, ack_d;
  logic             grant_q, grant_d;
  logic [31:0]      maddr_q, maddr_d;
  logic [31:0]      mwdata_q, mwdata_d;

  logic done;
  logic tmo;
  logic win;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q, cnt_d;
  logic        terr_q, terr_d;
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

  // Both pending: alternate away from the last owner.
  assign win = (pend_q == 2'b11) ? ~grant_q : ~pend_q[0];

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    dir_d    = dir_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = 2'b00;
    grant_d  = grant_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    done     = 1'b0;
    tmo      = 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
    cnt_d    = cnt_q;
    terr_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d  = ISSUE;
          grant_d  = win;
          maddr_d  = addr_q[win];
          mwdata_d = wdata_q[win];
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef MEM_ARBITER_TIMEOUT_EN
        cnt_d   = 16'd1;
`endif
      end
      WAIT: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
        if (mem_ack) begin
          done = 1'b1;
        end else if (cnt_q == TMO_LIM) begin
          done = 1'b1;
          tmo  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`else
        done = mem_ack;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      state_d        = IDLE;
      ack_d[grant_q] = 1'b1;
      pend_d[grant_q] = 1'b0;
      if (tmo) begin
        rdata_d[grant_q] = 32'hDEAD_BEEF;
`ifdef MEM_ARBITER_TIMEOUT_EN
        terr_d = 1'b1;
`endif
      end else if (!dir_q[grant_q]) begin
        rdata_d[grant_q] = mem_read_data;
      end
    end

    // A slot freed on this edge may be refilled on the same edge.
    if ((m0_read || m0_write) && !pend_d[0]) begin
      pend_d[0]  = 1'b1;
      dir_d[0]   = m0_write;
      addr_d[0]  = m0_addr;
      wdata_d[0] = m0_wdata;
    end
    if ((m1_read || m1_write) && !pend_d[1]) begin
      pend_d[1]  = 1'b1;
      dir_d[1]   = m1_write;
      addr_d[1]  = m1_addr;
      wdata_d[1] = m1_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      dir_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      grant_q  <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign mem_read       = (state_q == ISSUE) && !dir_q[grant_q];
  assign mem_write      = (state_q == ISSUE) &&  dir_q[grant_q];
  assign mem_addr       = maddr_q;
  assign mem_write_data = mwdata_q;
  assign m0_ack         = ack_q[0];
  assign m1_ack         = ack_q[1];
  assign m0_rdata       = rdata_q[0];
  assign m1_rdata       = rdata_q[1];
  assign busy           = (state_q != IDLE);
  assign grant          = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int T = 8;
`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, mem_read, mem_write, busy, grant, timeout_err;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_write_data;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_read_data = '0;

  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .busy(busy), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: pending table plus current owner.
  bit          mp[2], mw[2];
  logic [31:0] ma[2], md[2];
  bit          m_busy, m_issue, m_owner;
  int          wcnt;
  bit          e_ack[2];
  logic [31:0] e_rd[2];
  logic [31:0] e_addr, e_wd;
  bit          e_terr;

  always @(posedge clk) begin : model
    bit fin, tmo, who;
    if (reset) begin
      mp = '{0, 0}; m_busy = 0; m_issue = 0; m_owner = 0; wcnt = 0;
      e_ack = '{0, 0}; e_rd = '{0, 0}; e_addr = 0; e_wd = 0; e_terr = 0;
    end else begin
      fin = 0; tmo = 0; who = m_owner;
      e_ack = '{0, 0}; e_terr = 0;
      if (m_busy && m_issue) begin
        m_issue = 0;
        wcnt = 1;
      end else if (m_busy) begin
        if (mem_ack) fin = 1;
        else if (TMO_EN && wcnt == T) begin fin = 1; tmo = 1; end
        else wcnt++;
      end else if (mp[0] || mp[1]) begin
        m_owner = (mp[0] && mp[1]) ? !m_owner : mp[1];
        m_busy = 1; m_issue = 1;
        e_addr = ma[m_owner]; e_wd = md[m_owner];
      end
      if (fin) begin
        e_ack[who] = 1; mp[who] = 0; m_busy = 0;
        if (tmo) begin e_rd[who] = 32'hDEADBEEF; e_terr = 1; end
        else if (!mw[who]) e_rd[who] = mem_read_data;
      end
      if ((m0_read || m0_write) && !mp[0]) begin
        mp[0] = 1; mw[0] = m0_write; ma[0] = m0_addr; md[0] = m0_wdata;
      end
      if ((m1_read || m1_write) && !mp[1]) begin
        mp[1] = 1; mw[1] = m1_write; ma[1] = m1_addr; md[1] = m1_wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m0_ack", m0_ack, e_ack[0]);
      check("m1_ack", m1_ack, e_ack[1]);
      check("m0_rdata", m0_rdata, e_rd[0]);
      check("m1_rdata", m1_rdata, e_rd[1]);
      check("mem_read", mem_read, m_issue && !mw[m_owner]);
      check("mem_write", mem_write, m_issue && mw[m_owner]);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_write_data, e_wd);
      check("busy", busy, m_busy);
      check("grant", grant, m_owner);
      check("timeout_err", timeout_err, e_terr);
      check("ack_excl", m0_ack & m1_ack, 0);
      check("strobe_excl", mem_read & mem_write, 0);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clr();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic req(input bit m, input bit wr, input logic [31:0] a,
                     input logic [31:0] d);
    if (m) begin
      m1_read = !wr; m1_write = wr; m1_addr = a; m1_wdata = d;
    end else begin
      m0_read = !wr; m0_write = wr; m0_addr = a; m0_wdata = d;
    end
    step();
    clr();
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      step();
      n++;
    end
    check(name, mem_read | mem_write, 1);
  endtask

  task automatic respond(input int dly, input logic [31:0] data);
    repeat (dly) step();
    mem_ack = 1; mem_read_data = data;
    step();
    mem_ack = 0; mem_read_data = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s, a, n;
    step(); step();
    reset = 0;
    cmp_en = 1;

    // single write
    req(0, 1, 32'h0010000C, 32'h1337);
    check("t1_idle_at_latch", busy, 0);
    step();
    check("t1_mem_write", mem_write, 1);
    check("t1_mem_read", mem_read, 0);
    check("t1_addr", mem_addr, 32'h0010000C);
    check("t1_wdata", mem_write_data, 32'h1337);
    check("t1_grant", grant, 0);
    respond(3, 32'h0);
    check("t1_m0_ack", m0_ack, 1);
    check("t1_m1_ack", m1_ack, 0);
    step();
    check("t1_ack_once", m0_ack, 0);

    // simultaneous reads after reset
    do_reset();
    m0_read = 1; m0_addr = 32'h200;
    m1_read = 1; m1_addr = 32'h300;
    step(); clr();
    wait_strobe("t2_s1");
    check("t2_grant1", grant, 1);
    check("t2_read1", mem_read, 1);
    check("t2_addr1", mem_addr, 32'h300);
    respond(1, 32'h11111111);
    check("t2_m1_ack", m1_ack, 1);
    check("t2_m0_noack", m0_ack, 0);
    check("t2_m1_rdata", m1_rdata, 32'h11111111);
    wait_strobe("t2_s2");
    check("t2_grant0", grant, 0);
    check("t2_addr0", mem_addr, 32'h200);
    respond(2, 32'h22222222);
    check("t2_m0_ack", m0_ack, 1);
    check("t2_m0_rdata", m0_rdata, 32'h22222222);

    // read data capture and hold
    step();
    req(1, 0, 32'h100, 32'h0);
    wait_strobe("t3_s");
    check("t3_addr", mem_addr, 32'h100);
    respond(2, 32'hCAFEF00D);
    check("t3_m1_ack", m1_ack, 1);
    check("t3_m1_rdata", m1_rdata, 32'hCAFEF00D);
    check("t3_m0_rdata", m0_rdata, 32'h22222222);
    repeat (3) step();
    check("t3_hold", m1_rdata, 32'hCAFEF00D);

    // duplicate request ignored
    req(0, 0, 32'h10, 32'h0);
    req(0, 0, 32'h20, 32'h0);
    wait_strobe("t4_s");
    check("t4_addr", mem_addr, 32'h10);
    respond(1, 32'hA5A5A5A5);
    check("t4_m0_ack", m0_ack, 1);
    s = 0; a = 0;
    repeat (10) begin
      step();
      if (mem_read || mem_write) s++;
      if (m0_ack) a++;
    end
    check("t4_extra_strobes", s, 0);
    check("t4_extra_acks", a, 0);

    // reset during WAIT, late mem_ack
    req(0, 0, 32'h40, 32'h0);
    wait_strobe("t5_s");
    step();
    reset = 1; step(); reset = 0;
    step();
    mem_ack = 1; mem_read_data = 32'h99999999;
    step();
    mem_ack = 0; mem_read_data = 0;
    check("t5_m0_ack", m0_ack, 0);
    check("t5_m1_ack", m1_ack, 0);
    check("t5_busy", busy, 0);
    check("t5_strobes", mem_read | mem_write, 0);
    check("t5_rdata_clr", m0_rdata, 0);
    repeat (3) step();
    check("t5_busy_late", busy, 0);

    // requests latched during WAIT and on the completion edge
    req(0, 1, 32'h50, 32'h55);
    wait_strobe("t6_s0");
    step();
    m1_read = 1; m1_addr = 32'h60;
    step(); clr();
    step();
    mem_ack = 1;
    m0_read = 1; m0_addr = 32'h70;
    step();
    mem_ack = 0; clr();
    check("t6_m0_ack", m0_ack, 1);
    wait_strobe("t6_s1");
    check("t6_grant1", grant, 1);
    check("t6_addr1", mem_addr, 32'h60);
    respond(1, 32'h66666666);
    check("t6_m1_rdata", m1_rdata, 32'h66666666);
    wait_strobe("t6_s2");
    check("t6_grant0", grant, 0);
    check("t6_addr2", mem_addr, 32'h70);
    respond(1, 32'h77777777);
    check("t6_m0_rdata", m0_rdata, 32'h77777777);

`ifdef MEM_ARBITER_TIMEOUT_EN
    req(0, 0, 32'h80, 32'h0);
    wait_strobe("t7_s");
    n = 0;
    while (!m0_ack && n < 20) begin
      step();
      n++;
    end
    check("t7_latency", n, 9);
    check("t7_rdata", m0_rdata, 32'hDEADBEEF);
    check("t7_terr", timeout_err, 1);
    step();
    check("t7_terr_pulse", timeout_err, 0);
    check("t7_ack_pulse", m0_ack, 0);
    req(0, 0, 32'h90, 32'h0);
    wait_strobe("t8_s");
    repeat (8) step();
    mem_ack = 1; mem_read_data = 32'h12345678;
    step();
    mem_ack = 0; mem_read_data = 0;
    check("t8_ack", m0_ack, 1);
    check("t8_rdata", m0_rdata, 32'h12345678);
    check("t8_no_terr", timeout_err, 0);
`else
    req(0, 0, 32'h80, 32'h0);
    wait_strobe("t7_s");
    n = 0;
    repeat (30) begin
      step();
      if (m0_ack) n++;
    end
    check("t7_busy", busy, 1);
    check("t7_no_ack", n, 0);
    check("t7_no_terr", timeout_err, 0);
    do_reset();
    step();
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of WAIT cycles without mem_ack before forced termination (16-bit, 1..65535).
REQ-002 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports m0_read / m1_read, input, 1: one-cycle read request pulse from master 0 / 1.
REQ-005 SHALL have ports m0_write / m1_write, input, 1: one-cycle write request pulse.
REQ-006 SHALL have ports m0_addr / m1_addr and m0_wdata / m1_wdata, input, 32 each: address and write data, valid in the request-pulse cycle.
REQ-007 SHALL have ports m0_ack / m1_ack, output, 1: one-cycle completion pulse to the master.
REQ-008 SHALL have ports m0_rdata / m1_rdata, output, 32: read data, valid while the matching ack is high and held until the next completion.
REQ-009 SHALL have ports mem_read and mem_write, output, 1 each: one-cycle strobes to the memory bus.
REQ-010 SHALL have ports mem_addr and mem_write_data, output, 32 each: bus address and write data.
REQ-011 SHALL have port mem_ack, input, 1: bus completion.
REQ-012 SHALL have port mem_read_data, input, 32: bus read data, valid with mem_ack.
REQ-013 SHALL have port busy, output, 1: high when the state is not IDLE.
REQ-014 SHALL have port grant, output, 1: index of the master that owns or last owned the bus.
REQ-015 SHALL have port timeout_err, output, 1: one-cycle pulse on forced termination.

Function
REQ-016 SHALL latch a request per master (pending flag, direction, addr, wdata) on the edge where the read or write pulse is sampled.
REQ-017 SHALL treat write as taking priority over read when both pulse together from the same master.
REQ-018 SHALL ignore a request pulse from a master whose pending flag is already set; the original pending request is kept.
REQ-019 SHALL implement states IDLE, ISSUE and WAIT.
REQ-020 IDLE->ISSUE SHALL occur when any pending flag is set; with both pending, the winner is the master not equal to grant (round-robin); grant updates on this transition.
REQ-021 ISSUE SHALL drive exactly one cycle of mem_read or mem_write, with mem_addr and mem_write_data from the winner's latch, then go to WAIT.
REQ-022 Latency: a request sampled at edge N with the arbiter IDLE SHALL enter ISSUE at edge N+1, making the strobe visible in the cycle after N+1.
REQ-023 mem_addr and mem_write_data SHALL hold their values from ISSUE until the next ISSUE.
REQ-024 WAIT->IDLE SHALL occur on the edge sampling mem_ack=1; on that edge the arbiter captures mem_read_data into the granted mN_rdata (reads only), pulses mN_ack for one cycle, and clears that pending flag.
REQ-025 A new request from the just-completed master, sampled on its completion edge, SHALL be latched.
REQ-026 mem_ack SHALL be ignored in IDLE and ISSUE.
REQ-027 A request from either master SHALL be latchable in every state, including a request from the non-granted master during WAIT.
REQ-028 At most one mN_ack SHALL be high in any cycle.
REQ-029 mem_read and mem_write SHALL never be high together.

Reset
REQ-030 On reset, the arbiter SHALL go to IDLE and clear both pending flags, all strobes, m0_ack, m1_ack, timeout_err, busy, grant, the timeout counter, mem_addr, mem_write_data, m0_rdata and m1_rdata.
REQ-031 On reset mid-transaction, the in-flight request SHALL be dropped with no mN_ack, and a later mem_ack SHALL be ignored.

Configuration
REQ-032 With MEM_ARBITER_TIMEOUT_EN defined, the arbiter SHALL count WAIT cycles from 1.
REQ-033 With MEM_ARBITER_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES without mem_ack, the arbiter SHALL go to IDLE, pulse mN_ack, load mN_rdata = 32'hDEADBEEF, and pulse timeout_err, all on the same edge.
REQ-034 With MEM_ARBITER_TIMEOUT_EN defined, mem_ack on the same edge as the timeout SHALL win: normal completion, no timeout_err.
REQ-035 Without MEM_ARBITER_TIMEOUT_EN, WAIT SHALL last indefinitely, timeout_err SHALL be tied 0, and no counter SHALL be synthesised.

Verification
REQ-036 SHALL cover single write: m0_write, addr 0x0010000C, wdata 0x1337, mem_ack 3 cycles after the strobe -> one mem_write pulse with the same addr/data; m0_ack one cycle; grant=0.
REQ-037 SHALL cover simultaneous reads: m0_read and m1_read in the same cycle after reset -> m1 served first (grant was 0), then m0; two separate mem_read pulses; m1_ack precedes m0_ack.
REQ-038 SHALL cover read data: m1_read at 0x100, mem_read_data=0xCAFEF00D with mem_ack -> m1_rdata=0xCAFEF00D while m1_ack high, held afterwards; m0_rdata unchanged.
REQ-039 SHALL cover duplicate request: m0_read at 0x10, then m0_read at 0x20 while pending -> only address 0x10 issued; a single m0_ack.
REQ-040 SHALL cover reset mid-operation: reset asserted in WAIT, mem_ack arrives 2 cycles later -> no mN_ack, busy=0, mem_read=mem_write=0.
REQ-041 SHALL cover timeout (TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ack never asserted -> after 8 WAIT cycles m0_ack with m0_rdata=0xDEADBEEF and timeout_err pulse; with the macro undefined, busy stays 1.
